// File: rtl/vip_median_filter_3x3_8bit_pkg.sv
// Shared constants, types and compare helpers for the 3x3 median filter.
// Pixel width is fixed at 8 bits. The counters used by the optional border
// pass-through are 11 bits wide.
package vip_pkg;

  localparam int unsigned VIP_DATA_W   = 8;
  localparam int unsigned VIP_CNT_W    = 11;
  localparam int unsigned VIP_PIPE_LAT = 3;

  typedef logic [VIP_DATA_W-1:0] pix_t;
  typedef logic [VIP_CNT_W-1:0]  cnt_t;

  // Saturation value for the line and column counters.
  localparam cnt_t VIP_CNT_MAX = 11'h7FF;

  // Unsigned minimum of two pixels. On a tie either operand is correct.
  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  // Unsigned maximum of two pixels.
  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    return max2(max2(a, b), c);
  endfunction

  // The median is the larger of min(a,b) and min(max(a,b), c).
  function automatic pix_t mid3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

endpackage

// File: rtl/vip_median_filter_3x3_8bit_if.sv
// Pixel-stream bundle between the matrix generator and the median filter.
// The master drives the window and input syncs. The slave (the filter)
// drives the delayed syncs and the median.
interface vip_median_filter_3x3_8bit_if;
  import vip_pkg::*;

  logic per_frame_vsync;
  logic per_frame_href;
  logic per_frame_clken;
  pix_t matrix_p11, matrix_p12, matrix_p13;
  pix_t matrix_p21, matrix_p22, matrix_p23;
  pix_t matrix_p31, matrix_p32, matrix_p33;

  logic post_frame_vsync;
  logic post_frame_href;
  logic post_frame_clken;
  pix_t post_img_y;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_y
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_y
  );

endinterface

// File: rtl/vip_median_filter_3x3_8bit_sort3.sv
// One-clock registered three-input sorter. The outputs are the max, mid and
// min of the inputs sampled on the previous clock. This is the building block
// of every stage of the median network.
module vip_sort3_8bit
  import vip_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  pix_t in_a,
  input  pix_t in_b,
  input  pix_t in_c,
  output pix_t max,
  output pix_t mid,
  output pix_t min
);

  pix_t max_r, mid_r, min_r;

  // Register the sorted triple so that each network stage is exactly one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_r <= 8'h00;
      mid_r <= 8'h00;
      min_r <= 8'h00;
    end else begin
      max_r <= max3(in_a, in_b, in_c);
      mid_r <= mid3(in_a, in_b, in_c);
      min_r <= min3(in_a, in_b, in_c);
    end
  end

  assign max = max_r;
  assign mid = mid_r;
  assign min = min_r;

endmodule

// File: rtl/vip_median_filter_3x3_8bit.sv
// 3x3 median filter for an 8-bit pixel stream. The network has three
// registered stages:
//   stage 1 sorts each window row.
//   stage 2 takes the min of the row maxima, the median of the row mids and
//           the max of the row minima.
//   stage 3 takes the median of those three values.
// vsync, href and clken are delayed three clocks to line up with the median.
// post_img_y is forced to zero outside active lines.
// Optional feature (macro VIP_MEDIAN_BORDER_PASS_EN): pixels on the outer
// row or column of the image pass the centre pixel through unfiltered.
module vip_median_filter_3x3_8bit
  import vip_pkg::*;
#(
  parameter int unsigned IMG_H_DISP = 640,
  parameter int unsigned IMG_V_DISP = 480
)
(
  input logic                          clk,
  input logic                          rst_n,
  vip_median_filter_3x3_8bit_if.slave  bus
);

  // ---------------- stage 1: per-row sort ----------------
  pix_t row_max_s [3];
  pix_t row_mid_s [3];
  pix_t row_min_s [3];

  vip_sort3_8bit u_row1 (
    .clk(clk), .rst_n(rst_n),
    .in_a(bus.matrix_p11), .in_b(bus.matrix_p12), .in_c(bus.matrix_p13),
    .max(row_max_s[0]), .mid(row_mid_s[0]), .min(row_min_s[0])
  );

  vip_sort3_8bit u_row2 (
    .clk(clk), .rst_n(rst_n),
    .in_a(bus.matrix_p21), .in_b(bus.matrix_p22), .in_c(bus.matrix_p23),
    .max(row_max_s[1]), .mid(row_mid_s[1]), .min(row_min_s[1])
  );

  vip_sort3_8bit u_row3 (
    .clk(clk), .rst_n(rst_n),
    .in_a(bus.matrix_p31), .in_b(bus.matrix_p32), .in_c(bus.matrix_p33),
    .max(row_max_s[2]), .mid(row_mid_s[2]), .min(row_min_s[2])
  );

  // ---------------- stage 2: column reduction ----------------
  pix_t min_of_max_r;
  pix_t max_of_min_r;
  pix_t mid_of_mid_s;
  pix_t s2_unused_hi_s;
  pix_t s2_unused_lo_s;

  // The min of the maxima and the max of the minima are single compare chains.
  // They are registered here so that they stay level with the mid-of-mid sorter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_of_max_r <= 8'h00;
      max_of_min_r <= 8'h00;
    end else begin
      min_of_max_r <= min3(row_max_s[0], row_max_s[1], row_max_s[2]);
      max_of_min_r <= max3(row_min_s[0], row_min_s[1], row_min_s[2]);
    end
  end

  vip_sort3_8bit u_mid_of_mid (
    .clk(clk), .rst_n(rst_n),
    .in_a(row_mid_s[0]), .in_b(row_mid_s[1]), .in_c(row_mid_s[2]),
    .max(s2_unused_hi_s), .mid(mid_of_mid_s), .min(s2_unused_lo_s)
  );

  // ---------------- stage 3: final median ----------------
  pix_t median_s;
  pix_t s3_unused_hi_s;
  pix_t s3_unused_lo_s;

  vip_sort3_8bit u_final (
    .clk(clk), .rst_n(rst_n),
    .in_a(min_of_max_r), .in_b(mid_of_mid_s), .in_c(max_of_min_r),
    .max(s3_unused_hi_s), .mid(median_s), .min(s3_unused_lo_s)
  );

  // ---------------- sync alignment ----------------
  logic [VIP_PIPE_LAT-1:0] vsync_d_r;
  logic [VIP_PIPE_LAT-1:0] href_d_r;
  logic [VIP_PIPE_LAT-1:0] clken_d_r;

  // Three-deep shift registers. Tap 2 lines up with the stage 3 median.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_r <= 3'b000;
      href_d_r  <= 3'b000;
      clken_d_r <= 3'b000;
    end else begin
      vsync_d_r <= {vsync_d_r[VIP_PIPE_LAT-2:0], bus.per_frame_vsync};
      href_d_r  <= {href_d_r[VIP_PIPE_LAT-2:0],  bus.per_frame_href};
      clken_d_r <= {clken_d_r[VIP_PIPE_LAT-2:0], bus.per_frame_clken};
    end
  end

`ifdef VIP_MEDIAN_BORDER_PASS_EN
  // ---------------- border pass-through ----------------
  cnt_t                    col_cnt_r;
  cnt_t                    row_cnt_r;
  logic                    href_prev_r;
  logic                    border_s;
  logic [VIP_PIPE_LAT-1:0] border_d_r;
  pix_t                    p22_d_r [VIP_PIPE_LAT];

  // Column counter: counts pixels within a line. Row counter: counts line ends
  // within a frame. Both saturate at 2047.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_r   <= 11'd0;
      row_cnt_r   <= 11'd0;
      href_prev_r <= 1'b0;
    end else begin
      if (!bus.per_frame_href) begin
        col_cnt_r <= 11'd0;
      end else if (bus.per_frame_clken && (col_cnt_r != VIP_CNT_MAX)) begin
        col_cnt_r <= col_cnt_r + 11'd1;
      end else begin
        col_cnt_r <= col_cnt_r;
      end

      if (bus.per_frame_vsync) begin
        row_cnt_r <= 11'd0;
      end else if (href_prev_r && !bus.per_frame_href && (row_cnt_r != VIP_CNT_MAX)) begin
        row_cnt_r <= row_cnt_r + 11'd1;
      end else begin
        row_cnt_r <= row_cnt_r;
      end

      href_prev_r <= bus.per_frame_href;
    end
  end

  // A pixel is on the border if it lies in the first or last column or row.
  always_comb begin
    border_s = 1'b0;
    if ((col_cnt_r == 11'd0) || (col_cnt_r == cnt_t'(IMG_H_DISP - 1)) ||
        (row_cnt_r == 11'd0) || (row_cnt_r == cnt_t'(IMG_V_DISP - 1))) begin
      border_s = 1'b1;
    end else begin
      border_s = 1'b0;
    end
  end

  // Carry the border flag and the centre pixel alongside the sorting network.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      border_d_r <= 3'b000;
      for (int i = 0; i < VIP_PIPE_LAT; i++) begin
        p22_d_r[i] <= 8'h00;
      end
    end else begin
      border_d_r <= {border_d_r[VIP_PIPE_LAT-2:0], border_s};
      p22_d_r[0] <= bus.matrix_p22;
      for (int i = 1; i < VIP_PIPE_LAT; i++) begin
        p22_d_r[i] <= p22_d_r[i-1];
      end
    end
  end
`else
  // The image geometry only matters for border handling.
  localparam int unsigned geom_unused = IMG_H_DISP + IMG_V_DISP;
`endif

  pix_t post_y_s;

  // Output select: blank outside active lines. Otherwise output the median,
  // or the centre pixel on a border when that feature is built.
  always_comb begin
    post_y_s = 8'h00;
    if (href_d_r[VIP_PIPE_LAT-1]) begin
`ifdef VIP_MEDIAN_BORDER_PASS_EN
      if (border_d_r[VIP_PIPE_LAT-1]) begin
        post_y_s = p22_d_r[VIP_PIPE_LAT-1];
      end else begin
        post_y_s = median_s;
      end
`else
      post_y_s = median_s;
`endif
    end else begin
      post_y_s = 8'h00;
    end
  end

  assign bus.post_frame_vsync = vsync_d_r[VIP_PIPE_LAT-1];
  assign bus.post_frame_href  = href_d_r[VIP_PIPE_LAT-1];
  assign bus.post_frame_clken = clken_d_r[VIP_PIPE_LAT-1];
  assign bus.post_img_y       = post_y_s;

endmodule

// File: tb/tb_vip_median_filter_3x3_8bit.sv
// Self-checking bench for vip_median_filter_3x3_8bit. Each driven window
// pushes its expected output onto a scoreboard queue. The queue is primed with
// two reset-state entries, so the entry popped after every clock is the one
// driven three clocks earlier.
module tb_vip_median_filter_3x3_8bit;
  import vip_pkg::*;

  localparam int unsigned H = 4;
  localparam int unsigned V = 3;
`ifdef VIP_MEDIAN_BORDER_PASS_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vip_median_filter_3x3_8bit_if bus();

  vip_median_filter_3x3_8bit #(.IMG_H_DISP(H), .IMG_V_DISP(V)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vsync;
    logic       href;
    logic       clken;
    logic [7:0] y;
  } exp_t;

  typedef struct {
    logic            vsync;
    logic            href;
    logic            clken;
    logic [8:0][7:0] p;     // p[0]=p11 ... p[8]=p33
    logic [7:0]      med;   // median of the window before gating
  } vec_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;
  int unsigned m_col = 0;
  int unsigned m_row = 0;
  bit m_href_prev = 1'b0;

  function automatic logic [8:0][7:0] win(input logic [7:0] a, b, c, d, e, f, g, h, i);
    logic [8:0][7:0] w;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e;
    w[5] = f; w[6] = g; w[7] = h; w[8] = i;
    return w;
  endfunction

  // Reference sorter: three compare-and-swap steps.
  function automatic void tsort(input logic [7:0] a, b, c,
                                output logic [7:0] lo, md, hi);
    logic [7:0] x, y, z, t;
    x = a; y = b; z = c;
    if (x > y) begin t = x; x = y; y = t; end
    if (y > z) begin t = y; y = z; z = t; end
    if (x > y) begin t = x; x = y; y = t; end
    lo = x; md = y; hi = z;
  endfunction

  function automatic logic [7:0] model_med(input logic [8:0][7:0] p);
    logic [7:0] lo [3], md [3], hi [3];
    logic [7:0] a_lo, a_md, a_hi, b_lo, b_md, b_hi, c_lo, c_md, c_hi;
    logic [7:0] r_lo, r_md, r_hi;
    for (int r = 0; r < 3; r++) tsort(p[3*r], p[3*r+1], p[3*r+2], lo[r], md[r], hi[r]);
    tsort(hi[0], hi[1], hi[2], a_lo, a_md, a_hi);   // use a_lo
    tsort(md[0], md[1], md[2], b_lo, b_md, b_hi);   // use b_md
    tsort(lo[0], lo[1], lo[2], c_lo, c_md, c_hi);   // use c_hi
    tsort(a_lo, b_md, c_hi, r_lo, r_md, r_hi);
    return r_md;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vs, hr, ce, input logic [8:0][7:0] p);
    bus.per_frame_vsync = vs;
    bus.per_frame_href  = hr;
    bus.per_frame_clken = ce;
    bus.matrix_p11 = p[0]; bus.matrix_p12 = p[1]; bus.matrix_p13 = p[2];
    bus.matrix_p21 = p[3]; bus.matrix_p22 = p[4]; bus.matrix_p23 = p[5];
    bus.matrix_p31 = p[6]; bus.matrix_p32 = p[7]; bus.matrix_p33 = p[8];
  endtask

  task automatic prime_queue();
    exp_t z;
    z.vsync = 1'b0; z.href = 1'b0; z.clken = 1'b0; z.y = 8'h00;
    sb_q.delete();
    sb_q.push_back(z);
    sb_q.push_back(z);
    m_col = 0; m_row = 0; m_href_prev = 1'b0;
  endtask

  // Called at a falling edge. Drive one window, clock once, and compare the output.
  task automatic step(input logic vs, hr, ce, input logic [8:0][7:0] p, input logic [7:0] med);
    exp_t e;
    bit border;
    drive(vs, hr, ce, p);
    border = BORDER_EN && ((m_col == 0) || (m_col == H - 1) || (m_row == 0) || (m_row == V - 1));
    e.vsync = vs; e.href = hr; e.clken = ce;
    if (!hr) e.y = 8'h00;
    else if (border) e.y = p[4];
    else e.y = med;
    sb_q.push_back(e);
    if (!hr) m_col = 0;
    else if (ce && m_col != 2047) m_col++;
    if (vs) m_row = 0;
    else if (m_href_prev && !hr && m_row != 2047) m_row++;
    m_href_prev = hr;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("post_img_y",       bus.post_img_y,             e.y);
    check("post_frame_href",  8'(bus.post_frame_href),   8'(e.href));
    check("post_frame_vsync", 8'(bus.post_frame_vsync),  8'(e.vsync));
    check("post_frame_clken", 8'(bus.post_frame_clken),  8'(e.clken));
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_y"},     bus.post_img_y,             8'h00);
    check({tag, "_href"},  8'(bus.post_frame_href),   8'h00);
    check({tag, "_vsync"}, 8'(bus.post_frame_vsync),  8'h00);
    check({tag, "_clken"}, 8'(bus.post_frame_clken),  8'h00);
  endtask

  vec_t tbl [8];
  logic [8:0][7:0] w123, wbord, wz;

  initial begin
    wz    = win(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    w123  = win(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
    wbord = win(8'h22, 8'h22, 8'h22, 8'h22, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22);

    tbl[0] = '{1'b0, 1'b1, 1'b1, win(8'd9, 8'd1, 8'd5, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6), 8'd5};
    tbl[1] = '{1'b0, 1'b1, 1'b1, win(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'hFF};
    tbl[2] = '{1'b0, 1'b1, 1'b1, wz, 8'h00};
    tbl[3] = '{1'b0, 1'b1, 1'b1, win(8'h40, 8'h40, 8'h40, 8'h40, 8'hFF, 8'h40, 8'h40, 8'h40, 8'h40), 8'h40};
    tbl[4] = '{1'b0, 1'b1, 1'b1, w123, 8'd5};
    tbl[5] = '{1'b0, 1'b1, 1'b1, win(8'd10, 8'd20, 8'd30, 8'd200, 8'd100, 8'd0, 8'd50, 8'd50, 8'd50), 8'd50};
    tbl[6] = '{1'b0, 1'b1, 1'b0, w123, 8'd5};
    tbl[7] = '{1'b0, 1'b0, 1'b0, w123, 8'd5};

    // Hold reset, then check the reset state away from the active edge.
    drive(1'b0, 1'b0, 1'b0, wz);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    prime_queue();

    // Table vectors, back to back.
    for (int i = 0; i < 8; i++) step(tbl[i].vsync, tbl[i].href, tbl[i].clken, tbl[i].p, tbl[i].med);

    // href drops for two clocks mid-line.
    step(1'b0, 1'b1, 1'b1, w123, 8'd5);
    step(1'b0, 1'b1, 1'b1, w123, 8'd5);
    step(1'b0, 1'b0, 1'b0, w123, 8'd5);
    step(1'b0, 1'b0, 1'b0, w123, 8'd5);
    step(1'b0, 1'b1, 1'b1, w123, 8'd5);
    step(1'b0, 1'b1, 1'b1, w123, 8'd5);

    // Random windows and random syncs, checked against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [8:0][7:0] pr;
      for (int k = 0; k < 9; k++) pr[k] = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           pr, model_med(pr));
    end

    // Reset pulse of one clock in the middle of a line.
    step(1'b0, 1'b1, 1'b1, w123, 8'd5);
    step(1'b0, 1'b1, 1'b1, w123, 8'd5);
    drive(1'b0, 1'b0, 1'b0, wz);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    prime_queue();
    step(1'b0, 1'b1, 1'b0, wz, 8'h00);
    step(1'b0, 1'b1, 1'b1, win(8'd9, 8'd1, 8'd5, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6), 8'd5);
    step(1'b0, 1'b1, 1'b0, wz, 8'h00);
    step(1'b0, 1'b1, 1'b0, wz, 8'h00);

    // Frame of H x V pixels. The centre pixel and the median differ, so
    // border pass-through shows up when it is built.
    step(1'b1, 1'b0, 1'b0, wbord, 8'h22);
    step(1'b1, 1'b0, 1'b0, wbord, 8'h22);
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) step(1'b0, 1'b1, 1'b1, wbord, 8'h22);
      step(1'b0, 1'b0, 1'b0, wbord, 8'h22);
      step(1'b0, 1'b0, 1'b0, wbord, 8'h22);
    end

    // Drain the pipeline.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, wz, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
